// File: rtl/vote_session_ctrl.sv
// Voting session FSM: a timed window latches one ballot per voter, then one EVAL cycle feeds voter_case and captures its result.
// Done pulses 2 cycles after the last OPEN cycle; no backpressure, and start outside IDLE or casts outside OPEN are dropped.
module vote_session_ctrl #(
    parameter int WINDOW = 16,
    parameter int SESS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        cast,
    input  logic [3:0]        ballot,
    output logic [3:0]        voter_i,
    input  logic [2:0]        voter_o,
    output logic              busy,
    output logic              open,
    output logic [3:0]        voted,
    output logic [2:0]        result,
    output logic [2:0]        yes_cnt,
    output logic              done,
    output logic [SESS_W-1:0] sessions
);

    localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    typedef enum logic [1:0] {IDLE, OPEN, EVAL, DONE} state_t;

    state_t            state_q;
    logic [TW-1:0]     timer_q;
    logic [3:0]        ballot_q;
    logic [3:0]        voted_q;
    logic [3:0]        voter_i_q;
    logic [2:0]        result_q;
    logic [2:0]        yes_cnt_q;
    logic              done_q;
    logic              busy_q;
    logic              open_q;
    logic [SESS_W-1:0] sessions_q;

    logic [3:0] take;
    logic [3:0] voted_d;
    logic [3:0] ballot_d;
    logic [2:0] pop_d;

    // First cast per voter wins; later strobes from the same voter are masked.
    always_comb begin
        take     = cast & ~voted_q;
        voted_d  = voted_q | take;
        ballot_d = (ballot_q & ~take) | (ballot & take);
        pop_d    = 3'd0;
        for (int i = 0; i < 4; i++) begin
            pop_d = pop_d + {2'b00, ballot_q[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            ballot_q   <= '0;
            voted_q    <= '0;
            voter_i_q  <= '0;
            result_q   <= '0;
            yes_cnt_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            open_q     <= 1'b0;
            sessions_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= OPEN;
                        voted_q  <= '0;
                        ballot_q <= '0;
                        timer_q  <= TW'(WINDOW - 1);
                        busy_q   <= 1'b1;
                        open_q   <= 1'b1;
                    end
                end
                OPEN: begin
                    voted_q  <= voted_d;
                    ballot_q <= ballot_d;
                    // The final window cycle still accepts casts, so EVAL sees ballot_d.
                    if (timer_q == '0 || voted_d == 4'hF) begin
                        state_q   <= EVAL;
                        open_q    <= 1'b0;
                        voter_i_q <= ballot_d;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                EVAL: begin
                    result_q  <= voter_o;
                    yes_cnt_q <= pop_d;
                    voter_i_q <= '0;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    sessions_q <= sessions_q + 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign voter_i  = voter_i_q;
    assign busy     = busy_q;
    assign open     = open_q;
    assign voted    = voted_q;
    assign result   = result_q;
    assign yes_cnt  = yes_cnt_q;
    assign done     = done_q;
    assign sessions = sessions_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: two instances (8-bit and 4-bit session counters) share stimulus;
// a session-level model is compared every cycle, plus literal expectations per scenario.
module tb_vote_session_ctrl;

    localparam int WIN = 16;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] cast;
    logic [3:0] ballot;

    logic [3:0] vi8, vi4, voted8, voted4;
    logic [2:0] vo8, vo4, res8, res4, yes8, yes4;
    logic       busy8, busy4, open8, open4, done8, done4;
    logic [7:0] sess8;
    logic [3:0] sess4;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Stand-in for voter_case: {yes majority, tie, no majority}.
    function automatic logic [2:0] vote_fn(input logic [3:0] b);
        int n;
        n = $countones(b);
        return {n >= 3, n == 2, n <= 1};
    endfunction

    assign vo8 = vote_fn(vi8);
    assign vo4 = vote_fn(vi4);

    vote_session_ctrl #(.WINDOW(WIN), .SESS_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cast(cast), .ballot(ballot),
        .voter_i(vi8), .voter_o(vo8), .busy(busy8), .open(open8), .voted(voted8),
        .result(res8), .yes_cnt(yes8), .done(done8), .sessions(sess8)
    );

    vote_session_ctrl #(.WINDOW(WIN), .SESS_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .cast(cast), .ballot(ballot),
        .voter_i(vi4), .voter_o(vo4), .busy(busy4), .open(open4), .voted(voted4),
        .result(res4), .yes_cnt(yes4), .done(done4), .sessions(sess4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Session-level model: phase 0 idle, 1 window, 2 evaluate, 3 complete.
    int         ph  = 0;
    int         age = 0;
    logic [3:0] m_bal = '0, m_voted = '0;
    logic [2:0] m_res = '0, m_yes = '0;
    logic [7:0] m_s8 = '0;
    logic [3:0] m_s4 = '0;

    always @(posedge clk) begin
        if (rst) begin
            ph = 0; age = 0; m_bal = '0; m_voted = '0;
            m_res = '0; m_yes = '0; m_s8 = '0; m_s4 = '0;
        end else begin
            case (ph)
                0: if (start) begin
                    ph = 1; age = 0; m_bal = '0; m_voted = '0;
                end
                1: begin
                    for (int i = 0; i < 4; i++)
                        if (cast[i] && !m_voted[i]) begin
                            m_bal[i]   = ballot[i];
                            m_voted[i] = 1'b1;
                        end
                    age++;
                    if (age == WIN || m_voted == 4'hF) ph = 2;
                end
                2: begin
                    m_res = vote_fn(m_bal);
                    m_yes = 3'($countones(m_bal));
                    ph = 3;
                end
                default: begin
                    m_s8 = m_s8 + 8'd1;
                    m_s4 = m_s4 + 4'd1;
                    ph = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy8",  int'(busy8),  int'(ph != 0));
            chk("m_open8",  int'(open8),  int'(ph == 1));
            chk("m_done8",  int'(done8),  int'(ph == 3));
            chk("m_vi8",    int'(vi8),    (ph == 2) ? int'(m_bal) : 0);
            chk("m_voted8", int'(voted8), int'(m_voted));
            chk("m_res8",   int'(res8),   int'(m_res));
            chk("m_yes8",   int'(yes8),   int'(m_yes));
            chk("m_sess8",  int'(sess8),  int'(m_s8));
            chk("m_busy4",  int'(busy4),  int'(ph != 0));
            chk("m_done4",  int'(done4),  int'(ph == 3));
            chk("m_vi4",    int'(vi4),    (ph == 2) ? int'(m_bal) : 0);
            chk("m_res4",   int'(res4),   int'(m_res));
            chk("m_sess4",  int'(sess4),  int'(m_s4));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    int n_open;

    initial begin
        rst = 1'b1; start = 1'b1; cast = 4'hF; ballot = 4'hF;
        // Reset with toggling inputs
        step();
        chk_en = 1;
        start = 1'b0; cast = 4'h0;
        step();
        start = 1'b0; cast = 4'h0; ballot = 4'h0; rst = 1'b0;
        chk("rst_busy", int'(busy8), 0);
        chk("rst_open", int'(open8), 0);
        chk("rst_voted", int'(voted8), 0);
        chk("rst_sess", int'(sess8), 0);
        chk("rst_vi", int'(vi8), 0);

        // Early close: yes from voters 0..2, no from voter 3
        start = 1'b1; step(); start = 1'b0;
        ballot = 4'hF; cast = 4'b0001; step();
        cast = 4'b0010; step();
        cast = 4'b0100; step();
        ballot = 4'h0; cast = 4'b1000;
        chk("ec_open_last", int'(open8), 1);
        step();
        cast = 4'h0;
        chk("ec_eval_open", int'(open8), 0);
        chk("ec_eval_vi", int'(vi8), 4'b0111);
        chk("ec_eval_vo", int'(vo8), 3'b100);
        step();
        chk("ec_done", int'(done8), 1);
        chk("ec_yes", int'(yes8), 3);
        chk("ec_result", int'(res8), 3'b100);
        step();
        chk("ec_done_low", int'(done8), 0);
        chk("ec_sess", int'(sess8), 1);

        // Timeout: single cast on the last window cycle
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= WIN; k++) begin
            cast = (k == WIN) ? 4'b0001 : 4'b0000;
            ballot = 4'b0001;
            chk("to_open", int'(open8), 1);
            step();
        end
        cast = 4'h0;
        chk("to_eval_open", int'(open8), 0);
        chk("to_eval_vi", int'(vi8), 4'b0001);
        chk("to_voted", int'(voted8), 4'b0001);
        step();
        chk("to_yes", int'(yes8), 1);
        step();

        // Ignored inputs in IDLE, duplicate cast, start during OPEN
        cast = 4'hF; ballot = 4'hF; step();
        chk("ign_idle_voted", int'(voted8), 4'b0001);
        chk("ign_idle_busy", int'(busy8), 0);
        cast = 4'h0; start = 1'b1; step(); start = 1'b0;
        cast = 4'b0100; ballot = 4'b0100; step();
        cast = 4'b0100; ballot = 4'b0000; start = 1'b1; step();
        cast = 4'h0; start = 1'b0;
        n_open = 2;
        for (int g = 0; g < 40 && open8; g++) begin
            n_open++;
            step();
        end
        chk("dup_open_cycles", n_open, WIN);
        cast = 4'hF; ballot = 4'hF;
        chk("dup_eval_vi", int'(vi8), 4'b0100);
        step();
        chk("dup_yes", int'(yes8), 1);
        chk("dup_done_voted", int'(voted8), 4'b0100);
        step();
        cast = 4'h0; ballot = 4'h0;
        chk("dup_idle_voted", int'(voted8), 4'b0100);
        chk("dup_sess", int'(sess8), 3);

        // Abort mid-window
        start = 1'b1; step(); start = 1'b0;
        cast = 4'b0001; ballot = 4'hF; step();
        cast = 4'b0010; step();
        cast = 4'h0; rst = 1'b1; step(); rst = 1'b0;
        chk("ab_busy", int'(busy8), 0);
        chk("ab_voted", int'(voted8), 0);
        chk("ab_sess", int'(sess8), 0);
        for (int k = 0; k < 3; k++) begin
            chk("ab_no_done", int'(done8), 0);
            step();
        end
        start = 1'b1; step(); start = 1'b0;
        cast = 4'hF; ballot = 4'b1010; step();
        cast = 4'h0;
        chk("ab2_vi", int'(vi8), 4'b1010);
        step(); step();
        chk("ab2_sess", int'(sess8), 1);
        chk("ab2_res", int'(res8), 3'b010);

        // Sweep all ballot patterns
        rst = 1'b1; step(); rst = 1'b0;
        for (int p = 0; p < 17; p++) begin
            start = 1'b1; step(); start = 1'b0;
            cast = 4'hF; ballot = 4'(p); step();
            cast = 4'h0;
            chk("sw_vi", int'(vi8), p % 16);
            step();
            chk("sw_yes", int'(yes8), $countones(4'(p)));
            chk("sw_res", int'(res8), int'(vote_fn(4'(p))));
            step();
            if (p == 15) begin
                chk("sw_sess16", int'(sess8), 16);
                chk("sw_sess4_wrap0", int'(sess4), 0);
            end
        end
        chk("sw_sess17", int'(sess8), 17);
        chk("sw_sess4_wrap1", int'(sess4), 1);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vote_session_ctrl.md
Name: vote_session_ctrl

Overview:
Session controller for the 4-input voter datapath (voter_case). It opens a timed voting window, latches one ballot per voter, drives the latched ballot vector onto the voter's I input for one evaluation cycle, and captures the voter's O result. It also produces a yes-count tally and a completed-session counter. It sits between the voter buttons/strobes and voter_case; voter_case itself remains purely combinational.

Parameters:
WINDOW, 16, length of the voting window in clock cycles; legal range is WINDOW >= 1.
SESS_W, 8, width of the completed-session counter.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  request to open a session; sampled only in IDLE.
cast  in  4  per-voter cast strobe; bit i belongs to voter i.
ballot  in  4  per-voter ballot value (1 = yes); bit i is sampled when cast[i]=1.
voter_i  out  4  drives voter_case.I.
voter_o  in  3  from voter_case.O (combinational response to voter_i).
busy  out  1  high when state != IDLE.
open  out  1  high when state == OPEN.
voted  out  4  bit i set once voter i has cast in the current session.
result  out  3  voter_o captured during EVAL.
yes_cnt  out  3  popcount of the latched ballots (0..4).
done  out  1  one-cycle pulse when a session completes.
sessions  out  SESS_W  count of completed sessions; wraps to 0 after the maximum value.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - voter_i, voted, result, yes_cnt, done, sessions, busy and open are all 0.
  - The internal ballot register and timer are 0.
  - rst has priority over every other input.
- Reset mid-session: the session is aborted, no done pulse is produced, and sessions returns to 0.
- States: IDLE -> OPEN -> EVAL -> DONE -> IDLE.
- IDLE:
  - start=1 moves to OPEN next cycle.
  - On that transition: clear voted and the ballot register, and load timer=WINDOW-1.
  - result and yes_cnt hold their previous values.
- start outside IDLE is ignored; it is neither queued nor restarted.
- OPEN, every cycle, for each i:
  - If cast[i]=1 and voted[i]=0: ballot_reg[i] <= ballot[i] and voted[i] <= 1.
  - Repeat casts are ignored; the first cast wins.
  - Casts are accepted on every OPEN cycle, including the final one.
- OPEN exit:
  - Go to EVAL when timer==0, or when the post-update voted vector equals 4'b1111 (early close).
  - Otherwise the timer decrements.
  - A full window is therefore exactly WINDOW OPEN cycles.
- Voters that never cast keep ballot_reg[i]=0 and are counted as no.
- voter_i equals ballot_reg during EVAL only, and 4'b0000 in all other states.
- EVAL (1 cycle):
  - result <= voter_o.
  - yes_cnt <= popcount(ballot_reg).
  - Next state is DONE.
- DONE (1 cycle):
  - done=1.
  - sessions <= sessions+1, with modulo 2^SESS_W wrap.
  - Next state is IDLE.
- Latency: the done pulse occurs 2 cycles after the last OPEN cycle.
- Minimum session is 1 OPEN + EVAL + DONE = 3 busy cycles.
- Back-to-back sessions: start can be accepted in the first IDLE cycle after DONE; a start asserted during DONE is lost.
- cast and ballot are ignored outside OPEN.
- voted stays visible from the end of a session until the next start.

Test Plan:
1. Reset check: assert rst for 2 cycles with start and cast toggling. Every output must read 0 and the state must stay IDLE.
2. Early close:
   - Stimulus: start, then cast yes from voters 0, 1, 2 on separate cycles and cast no from voter 3.
   - OPEN must end in the cycle voter 3 casts.
   - The next cycle must show voter_i=4'b0111, with result equal to voter_o at that cycle.
   - yes_cnt=3.
   - done must pulse 2 cycles after voter 3's cast, and sessions must read 1.
3. Timeout:
   - Stimulus: WINDOW=16, only voter 0 casts yes, on OPEN cycle 16.
   - The cast must be accepted and OPEN must last exactly 16 cycles.
   - voter_i=4'b0001 in EVAL, yes_cnt=1, voted=4'b0001.
4. Duplicate and ignored inputs:
   - Voter 2 casts 1 and later casts 0: the latched bit must stay 1.
   - cast pulses in IDLE, EVAL or DONE must have no effect.
   - A start asserted during OPEN must not restart the timer.
5. Abort: rst in the middle of OPEN after 2 casts must give IDLE, voted=0, sessions=0 and no done pulse. A new start must then run normally.
6. Exhaustive sweep:
   - Run 16 sessions covering ballot patterns 0000..1111, all voters casting.
   - Compare result against a behavioural voter_case model and yes_cnt against popcount.
   - sessions must read 16.
   - With SESS_W=4, one further session must wrap sessions to 1.
